// File: rtl/mc_controller.sv
// Multicycle MIPS-style control FSM: Moore state decode plus ALU control decode.
// Optional BNE support is compiled in when the MC_BNE_EN macro is defined.
module mc_controller #(
  parameter int unsigned FETCH_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       alusrca,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11,
    BNEEX   = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [1:0] WAIT_INIT = 2'(FETCH_WAIT);

  state_t     state_q, state_d;
  logic [1:0] wait_q, wait_d;

  // Every path into FETCH reloads the wait count, so wait_d defaults to the reload value.
  always_comb begin
    state_d = FETCH;
    wait_d  = WAIT_INIT;
    case (state_q)
      FETCH: begin
        if (wait_q == 2'd0) begin
          state_d = DECODE;
        end else begin
          state_d = FETCH;
          wait_d  = wait_q - 2'd1;
        end
      end
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = BNEEX;
`endif
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      wait_q  <= WAIT_INIT;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  logic       pcwrite_c, irwrite_c, memwrite_c, regwrite_c, branch_c;
  logic [1:0] aluop;

  always_comb begin
    pcwrite_c  = 1'b0;
    irwrite_c  = 1'b0;
    memwrite_c = 1'b0;
    regwrite_c = 1'b0;
    branch_c   = 1'b0;
    iord       = 1'b0;
    alusrca    = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = 2'b00;
    case (state_q)
      FETCH: begin
        alusrcb = 2'b01;
        if (wait_q == 2'd0) begin
          irwrite_c = 1'b1;
          pcwrite_c = 1'b1;
        end
      end
      DECODE:  alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:   iord = 1'b1;
      MEMWB: begin
        regwrite_c = 1'b1;
        memtoreg   = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_c = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      RTYPEWB: begin
        regwrite_c = 1'b1;
        regdst     = 1'b1;
      end
      ADDIWB:  regwrite_c = 1'b1;
      BEQEX: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsrc    = 2'b01;
        branch_c = zero;
      end
`ifdef MC_BNE_EN
      BNEEX: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsrc    = 2'b01;
        branch_c = ~zero;
      end
`endif
      JEX: begin
        pcsrc     = 2'b10;
        pcwrite_c = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

  // Reset already forces FETCH; gating keeps the wait-0 FETCH strobes quiet while reset is held.
  assign pcen     = (pcwrite_c | branch_c) & ~reset;
  assign irwrite  = irwrite_c & ~reset;
  assign memwrite = memwrite_c & ~reset;
  assign regwrite = regwrite_c & ~reset;
  assign state    = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class through the FSM
// with default FETCH_WAIT, plus a second instance with FETCH_WAIT=2.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset, reset2;
  logic [5:0] op, funct;
  logic       zero;

  logic       pcen, irwrite, memwrite, regwrite, iord, alusrca, memtoreg, regdst;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  logic       pcen2, irwrite2, memwrite2, regwrite2, iord2, alusrca2, memtoreg2, regdst2;
  logic [1:0] alusrcb2, pcsrc2;
  logic [2:0] alucontrol2;
  logic [3:0] state2;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .iord(iord), .alusrca(alusrca), .memtoreg(memtoreg), .regdst(regdst),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
  );

  mc_controller #(.FETCH_WAIT(2)) dut2 (
    .clk(clk), .reset(reset2), .op(6'b100011), .funct(6'b000000), .zero(1'b0),
    .pcen(pcen2), .irwrite(irwrite2), .memwrite(memwrite2), .regwrite(regwrite2),
    .iord(iord2), .alusrca(alusrca2), .memtoreg(memtoreg2), .regdst(regdst2),
    .alusrcb(alusrcb2), .pcsrc(pcsrc2), .alucontrol(alucontrol2), .state(state2)
  );

  logic [14:0] obs;
  assign obs = {pcen, irwrite, memwrite, regwrite, iord, alusrca, memtoreg, regdst,
                alusrcb, pcsrc, alucontrol};

  function automatic logic [14:0] ov(input logic pc, input logic irw, input logic mw,
                                     input logic rw, input logic io, input logic asa,
                                     input logic m2r, input logic rd, input logic [1:0] asb,
                                     input logic [1:0] pcs, input logic [2:0] aluc);
    return {pc, irw, mw, rw, io, asa, m2r, rd, asb, pcs, aluc};
  endfunction

  task automatic chk(input string tag, input logic [14:0] o, input logic [14:0] e);
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] st, input logic [14:0] v);
    chk({tag, "_state"}, {11'd0, state}, {11'd0, st});
    chk({tag, "_outs"}, obs, v);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  logic [14:0] V_RST, V_FETCH, V_DEC, V_MEMADR, V_MEMRD, V_MEMWB, V_MEMWR;
  logic [14:0] V_RTWB, V_ADDIWB, V_JEX;

  initial begin
    V_RST    = ov(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010);
    V_FETCH  = ov(1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010);
    V_DEC    = ov(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010);
    V_MEMADR = ov(0, 0, 0, 0, 0, 1, 0, 0, 2'b10, 2'b00, 3'b010);
    V_MEMRD  = ov(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b010);
    V_MEMWB  = ov(0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010);
    V_MEMWR  = ov(0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b010);
    V_RTWB   = ov(0, 0, 0, 1, 0, 0, 0, 1, 2'b00, 2'b00, 3'b010);
    V_ADDIWB = ov(0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010);
    V_JEX    = ov(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b010);

    reset = 1'b1; reset2 = 1'b1;
    op = 6'b100011; funct = 6'b000000; zero = 1'b0;
    #2;
    step("reset", 4'd0, V_RST);

    // lw: 0,1,2,3,4,0
    @(negedge clk); reset = 1'b0; #1;
    step("lw_fetch", 4'd0, V_FETCH);
    tick(); step("lw_dec", 4'd1, V_DEC);
    tick(); step("lw_adr", 4'd2, V_MEMADR);
    tick(); step("lw_rd", 4'd3, V_MEMRD);
    tick(); step("lw_wb", 4'd4, V_MEMWB);
    tick(); step("lw_end", 4'd0, V_FETCH);

    // R-type slt, then sub, then an unlisted funct
    op = 6'b000000; funct = 6'b101010;
    tick(); step("slt_dec", 4'd1, V_DEC);
    tick(); step("slt_ex", 4'd6, ov(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b111));
    tick(); step("slt_wb", 4'd7, V_RTWB);
    tick(); step("slt_end", 4'd0, V_FETCH);
    funct = 6'b100010;
    tick(); tick(); step("sub_ex", 4'd6, ov(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b110));
    tick(); tick(); step("sub_end", 4'd0, V_FETCH);
    funct = 6'b100101;
    tick(); tick(); step("or_ex", 4'd6, ov(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b001));
    tick(); tick();
    funct = 6'b111111;
    tick(); tick(); step("oth_ex", 4'd6, ov(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b010));
    tick(); tick(); step("oth_end", 4'd0, V_FETCH);

    // beq taken and not taken
    op = 6'b000100; zero = 1'b1;
    tick(); tick(); step("beq_t_ex", 4'd8, ov(1, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 3'b110));
    tick(); step("beq_t_end", 4'd0, V_FETCH);
    zero = 1'b0;
    tick(); tick(); step("beq_n_ex", 4'd8, ov(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 3'b110));
    tick(); step("beq_n_end", 4'd0, V_FETCH);

    // bne with zero=0
    op = 6'b000101;
    tick(); step("bne_dec", 4'd1, V_DEC);
`ifdef MC_BNE_EN
    tick(); step("bne_ex", 4'd12, ov(1, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 3'b110));
`endif
    tick(); step("bne_end", 4'd0, V_FETCH);

    // jump
    op = 6'b000010;
    tick(); tick(); step("j_ex", 4'd11, V_JEX);
    tick(); step("j_end", 4'd0, V_FETCH);

    // addi
    op = 6'b001000;
    tick(); tick(); step("addi_ex", 4'd9, V_MEMADR);
    tick(); step("addi_wb", 4'd10, V_ADDIWB);
    tick(); step("addi_end", 4'd0, V_FETCH);

    // unrecognised opcode runs as NOP
    op = 6'b111111;
    tick(); step("nop_dec", 4'd1, V_DEC);
    tick(); step("nop_end", 4'd0, V_FETCH);

    // sw interrupted by reset while in MEMWR
    op = 6'b101011;
    tick(); tick(); step("sw_adr", 4'd2, V_MEMADR);
    tick(); step("sw_wr", 4'd5, V_MEMWR);
    #1 reset = 1'b1;
    #1 step("sw_rst", 4'd0, V_RST);
    @(negedge clk); reset = 1'b0; #1;
    step("post_rst", 4'd0, V_FETCH);

    // FETCH_WAIT=2 instance: three FETCH cycles, irwrite only in the third
    chk("w2_rst_irw", {14'd0, irwrite2}, 15'd0);
    @(negedge clk); reset2 = 1'b0; #1;
    chk("w2_f0_state", {11'd0, state2}, 15'd0);
    chk("w2_f0_irw", {14'd0, irwrite2}, 15'd0);
    tick();
    chk("w2_f1_state", {11'd0, state2}, 15'd0);
    chk("w2_f1_irw", {14'd0, irwrite2}, 15'd0);
    tick();
    chk("w2_f2_state", {11'd0, state2}, 15'd0);
    chk("w2_f2_irw", {14'd0, irwrite2}, 15'd1);
    chk("w2_f2_pcen", {14'd0, pcen2}, 15'd1);
    tick();
    chk("w2_dec_state", {11'd0, state2}, 15'd1);
    chk("w2_dec_irw", {14'd0, irwrite2}, 15'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter: FETCH_WAIT, default 0, extra memory wait cycles inserted in FETCH before the instruction is captured (legal 0..3).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op  input  6  instruction opcode field (instr[31:26]).
REQ-005 funct  input  6  R-type function field (instr[5:0]).
REQ-006 zero  input  1  ALU zero flag.
REQ-007 pcen  output  1  PC register enable.
REQ-008 irwrite, memwrite, regwrite  output  1 each  IR load, memory write and register-file write strobes.
REQ-009 iord, alusrca, memtoreg, regdst  output  1 each  datapath mux selects.
REQ-010 alusrcb, pcsrc  output  2 each  ALU B-operand select and next-PC select.
REQ-011 alucontrol  output  3  ALU operation code.
REQ-012 state  output  4  current FSM state, for debug.

Function
REQ-013 Moore FSM with 4-bit encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, BNEEX=12; codes 13-15 SHALL go to FETCH on the next edge.
REQ-014 Transitions: FETCH->DECODE after the wait count expires; DECODE->MEMADR (op 100011/101011), RTYPEEX (000000), BEQEX (000100), ADDIEX (001000), JEX (000010), BNEEX (000101, macro only); MEMADR->MEMRD (lw) or MEMWR (sw); MEMRD->MEMWB; RTYPEEX->RTYPEWB; ADDIEX->ADDIWB; MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, BNEEX and JEX->FETCH.
REQ-015 An unrecognised opcode in DECODE SHALL return to FETCH with no write strobe asserted (executes as NOP).
REQ-016 FETCH: 2-bit wait counter loads FETCH_WAIT on entry and decrements each cycle; iord=0, alusrca=0, alusrcb=01, pcsrc=00 throughout; irwrite=1 and pcwrite=1 only in the cycle the counter is 0.
REQ-017 Per-state outputs (unlisted outputs 0): DECODE alusrcb=11; MEMADR/ADDIEX alusrca=1, alusrcb=10; MEMRD iord=1; MEMWB regwrite=1, memtoreg=1; MEMWR iord=1, memwrite=1; RTYPEEX alusrca=1, aluop=10; RTYPEWB regwrite=1, regdst=1; ADDIWB regwrite=1; BEQEX/BNEEX alusrca=1, aluop=01, pcsrc=01; JEX pcsrc=10, pcwrite=1.
REQ-018 pcen = pcwrite | (BEQEX & zero) | (BNEEX & ~zero), combinational from state and zero.
REQ-019 alucontrol: aluop 00->010 (add); 01->110 (sub); 10 decodes funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, any other funct->010.
REQ-020 Latency from FETCH entry with FETCH_WAIT=0: lw 5 cycles, sw/R-type/addi 4, beq/bne/j 3; each FETCH_WAIT step adds 1 cycle.
REQ-021 Write strobes SHALL each be asserted for exactly one cycle per instruction.

Reset
REQ-022 Asserting reset at any time, including mid-instruction, SHALL force state=FETCH and wait counter=FETCH_WAIT immediately, without waiting for a clock edge.
REQ-023 During reset, irwrite, memwrite, regwrite and pcen SHALL be 0; other outputs SHALL take their FETCH values.
REQ-024 After reset deasserts, the first rising edge SHALL begin FETCH counting.

Configuration
REQ-025 Macro MC_BNE_EN defined: opcode 000101 decodes to BNEEX per REQ-014/REQ-018.
REQ-026 MC_BNE_EN undefined: BNEEX logic is absent, opcode 000101 follows REQ-015, and state code 12 follows the REQ-013 recovery rule.

Verification
REQ-027 Reset, then op=100011, FETCH_WAIT=0 -> states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; pcen=1 only in state 0.
REQ-028 op=000000, funct=101010 -> alucontrol=111 in RTYPEEX; regwrite=1 and regdst=1 in RTYPEWB.
REQ-029 op=000100 in BEQEX with zero=1 -> pcen=1, pcsrc=01; repeat with zero=0 -> pcen=0.
REQ-030 op=111111 -> DECODE->FETCH; no write strobe asserted for the whole instruction.
REQ-031 Reset asserted mid-cycle while in MEMWR -> state=0 and memwrite=0 before the next clock edge.
REQ-032 FETCH_WAIT=2 -> 3 FETCH cycles; irwrite=1 only in the third.
